// File: rtl/rnn_mem_host.sv
// rnn_mem_host: weight/bias/config/output banks, input-vector FIFO and run handshake for the RNN core.
module rnn_mem_host #(
   parameter int T_MAX    = 16,
   parameter int XQ_DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        busy,
   output logic        ready,
   input  logic        i_en,
   output logic [31:0] idata,
   input  logic        mce,
   input  logic [2:0]  msel,
   input  logic [16:0] maddr,
   input  logic [19:0] mdata_w,
   output logic [19:0] mdata_r,
   input  logic        ld_en,
   input  logic [2:0]  ld_sel,
   input  logic [16:0] ld_addr,
   input  logic [19:0] ld_data,
   input  logic        x_push,
   input  logic [31:0] x_data,
   output logic        x_full,
   input  logic        start,
   output logic        done,
   input  logic [16:0] rd_addr,
   output logic [19:0] rd_data,
   output logic        err
);
   localparam int OW = $clog2(T_MAX * 64);
   localparam int AW = $clog2(XQ_DEPTH);
   typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;
   state_t state, state_nx;
   logic [19:0] wih [2048];
   logic [19:0] bih [64];
   logic [19:0] whh [4096];
   logic [19:0] bhh [64];
   logic [19:0] cfg;
   logic [19:0] out_mem [T_MAX*64];
   logic [31:0] xq [XQ_DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0] cnt, cnt_nx;
   logic ld_ok, wr_hit, wr_ok, push_ok, pop_ok, empty;
   assign ready   = state == ARMED;
   assign ld_ok   = ld_en & ~busy & ~ready;
   assign wr_hit  = mce && msel == 3'b101;
   assign wr_ok   = wr_hit && maddr[16:6] < 11'(T_MAX);
   assign empty   = cnt == '0;
   assign pop_ok  = i_en & ~empty;
   // a full FIFO still accepts a push when the same edge pops
   assign push_ok = x_push & (~x_full | pop_ok);
   assign cnt_nx  = cnt + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
   assign idata   = empty ? '0 : xq[rp];
   assign rd_data = rd_addr[16:6] < 11'(T_MAX) ? out_mem[rd_addr[OW-1:0]] : '0;
   always_comb begin
      state_nx = (state == IDLE && start) ? ARMED :
                 (state == ARMED && busy) ? RUN :
                 (state == RUN && !busy) ? IDLE : state;
   end
   always_comb begin
      mdata_r = '0;
      if (mce)
         case (msel)
            3'd0:    mdata_r = maddr < 17'd2048 ? wih[maddr[10:0]] : '0;
            3'd1:    mdata_r = maddr < 17'd64 ? bih[maddr[5:0]] : '0;
            3'd2:    mdata_r = maddr < 17'd4096 ? whh[maddr[11:0]] : '0;
            3'd3:    mdata_r = maddr < 17'd64 ? bhh[maddr[5:0]] : '0;
            3'd4:    mdata_r = maddr == '0 ? cfg : '0;
            default: mdata_r = '0;
         endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state  <= IDLE;
         done   <= 1'b0;
         err    <= 1'b0;
         x_full <= 1'b0;
         cnt    <= '0;
         wp     <= '0;
         rp     <= '0;
      end else begin
         state  <= state_nx;
         done   <= state == RUN && !busy;
         err    <= err | (wr_hit & ~wr_ok) | (x_push & ~push_ok) | (i_en & empty);
         x_full <= cnt_nx == (AW+1)'(XQ_DEPTH);
         cnt    <= cnt_nx;
         wp     <= wp + AW'(push_ok);
         rp     <= rp + AW'(pop_ok);
      end
   // storage is deliberately left out of reset so loads survive it
   always_ff @(posedge clk) begin
      if (push_ok) xq[wp] <= x_data;
      if (wr_ok) out_mem[maddr[OW-1:0]] <= mdata_w;
      if (ld_ok)
         case (ld_sel)
            3'd0:    if (ld_addr < 17'd2048) wih[ld_addr[10:0]] <= ld_data;
            3'd1:    if (ld_addr < 17'd64) bih[ld_addr[5:0]] <= ld_data;
            3'd2:    if (ld_addr < 17'd4096) whh[ld_addr[11:0]] <= ld_data;
            3'd3:    if (ld_addr < 17'd64) bhh[ld_addr[5:0]] <= ld_data;
            3'd4:    if (ld_addr == '0) cfg <= ld_data;
            default: ;
         endcase
   end
endmodule

// File: tb/tb_rnn_mem_host.sv
// tb_rnn_mem_host: directed table-driven read checks plus handshake, FIFO and output-bank sequences.
module tb_rnn_mem_host;
   logic        clk = 1'b0, reset = 1'b1, busy = 1'b0, i_en = 1'b0, mce = 1'b0;
   logic        ld_en = 1'b0, x_push = 1'b0, start = 1'b0;
   logic [2:0]  msel = '0, ld_sel = '0;
   logic [16:0] maddr = '0, ld_addr = '0, rd_addr = '0;
   logic [19:0] mdata_w = '0, ld_data = '0;
   logic [31:0] x_data = '0;
   logic        ready, x_full, done, err;
   logic [31:0] idata;
   logic [19:0] mdata_r, rd_data;
   int n_cmp = 0, n_bad = 0;
   rnn_mem_host #(.T_MAX(16), .XQ_DEPTH(16)) dut (
      .clk(clk), .reset(reset), .busy(busy), .ready(ready), .i_en(i_en), .idata(idata),
      .mce(mce), .msel(msel), .maddr(maddr), .mdata_w(mdata_w), .mdata_r(mdata_r),
      .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
      .x_push(x_push), .x_data(x_data), .x_full(x_full), .start(start), .done(done),
      .rd_addr(rd_addr), .rd_data(rd_data), .err(err)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic        mce;
      logic [2:0]  sel;
      logic [16:0] addr;
      logic [19:0] exp;
   } rd_vec_t;
   rd_vec_t vt [11];
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic load(input logic [2:0] s, input logic [16:0] a, input logic [19:0] d);
      ld_en = 1'b1; ld_sel = s; ld_addr = a; ld_data = d;
      tick();
      ld_en = 1'b0;
   endtask
   task automatic push(input logic [31:0] d);
      x_push = 1'b1; x_data = d;
      tick();
      x_push = 1'b0;
   endtask
   task automatic core_rd(input string name, input logic [2:0] s, input logic [16:0] a, input logic [19:0] e);
      mce = 1'b1; msel = s; maddr = a;
      #1;
      check(name, 32'(mdata_r), 32'(e));
      mce = 1'b0;
   endtask
   initial begin
      vt[0]  = '{1'b1, 3'd0, 17'h65, 20'h12345};
      vt[1]  = '{1'b1, 3'd3, 17'd7, 20'hFFFFE};
      vt[2]  = '{1'b1, 3'd6, 17'h65, 20'h0};
      vt[3]  = '{1'b0, 3'd0, 17'h65, 20'h0};
      vt[4]  = '{1'b1, 3'd2, 17'd66, 20'h00777};
      vt[5]  = '{1'b1, 3'd4, 17'd0, 20'h00005};
      vt[6]  = '{1'b1, 3'd4, 17'd1, 20'h0};
      vt[7]  = '{1'b1, 3'd0, 17'd2048, 20'h0};
      vt[8]  = '{1'b1, 3'd3, 17'd64, 20'h0};
      vt[9]  = '{1'b1, 3'd1, 17'd5, 20'h00042};
      vt[10] = '{1'b1, 3'd7, 17'd0, 20'h0};
      tick(); tick();
      check("rst_ready", 32'(ready), 0);
      check("rst_done", 32'(done), 0);
      check("rst_err", 32'(err), 0);
      check("rst_xfull", 32'(x_full), 0);
      check("rst_idata", idata, 0);
      reset = 1'b0;
      tick();
      load(3'd0, 17'h65, 20'h12345);
      load(3'd3, 17'd7, 20'hFFFFE);
      load(3'd2, 17'd66, 20'h00777);
      load(3'd4, 17'd0, 20'h00005);
      load(3'd1, 17'd5, 20'h00042);
      load(3'd1, 17'd64, 20'h00099);
      load(3'd5, 17'd0, 20'h00111);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_ready", 32'(ready), 1);
      for (int i = 0; i < 11; i++) begin
         mce = vt[i].mce; msel = vt[i].sel; maddr = vt[i].addr;
         #1;
         check($sformatf("rd_vec%0d", i), 32'(mdata_r), 32'(vt[i].exp));
      end
      mce = 1'b0;
      check("out_bank_unwritten", 32'(rd_data), 0);
      load(3'd0, 17'h65, 20'h11111);
      tick(); tick();
      check("ready_hold", 32'(ready), 1);
      core_rd("ld_ignored_armed", 3'd0, 17'h65, 20'h12345);
      busy = 1'b1;
      tick();
      check("ready_drop", 32'(ready), 0);
      check("done_in_run", 32'(done), 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      load(3'd3, 17'd7, 20'h00001);
      for (int i = 0; i < 7; i++) tick();
      check("done_still_low", 32'(done), 0);
      busy = 1'b0;
      tick();
      check("done_pulse", 32'(done), 1);
      tick();
      check("done_clear", 32'(done), 0);
      check("start_in_run_ignored", 32'(ready), 0);
      core_rd("ld_ignored_busy", 3'd3, 17'd7, 20'hFFFFE);
      push(32'hA5A5A5A5);
      push(32'h0F0F0F0F);
      check("fifo_head0", idata, 32'hA5A5A5A5);
      i_en = 1'b1;
      #1;
      check("fifo_sample", idata, 32'hA5A5A5A5);
      tick();
      check("fifo_head1", idata, 32'h0F0F0F0F);
      tick();
      check("fifo_empty_idata", idata, 0);
      check("fifo_err_before", 32'(err), 0);
      tick();
      i_en = 1'b0;
      check("fifo_underflow_err", 32'(err), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      check("err_cleared", 32'(err), 0);
      mce = 1'b1; msel = 3'd5; maddr = 17'hBF; mdata_w = 20'h00ABC;
      #1;
      check("rd_bank5_zero", 32'(mdata_r), 0);
      tick();
      mce = 1'b0;
      rd_addr = 17'hBF;
      #1;
      check("out_write", 32'(rd_data), 20'h00ABC);
      check("out_write_noerr", 32'(err), 0);
      mce = 1'b1; maddr = 17'd1024; mdata_w = 20'h00DEF;
      tick();
      mce = 1'b0;
      check("out_drop_err", 32'(err), 1);
      rd_addr = 17'd1024;
      #1;
      check("out_drop_rd", 32'(rd_data), 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      busy = 1'b1;
      tick();
      push(32'h12121212);
      check("run_state", 32'(ready), 0);
      check("run_fifo", idata, 32'h12121212);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_ready", 32'(ready), 0);
      check("mid_rst_done", 32'(done), 0);
      check("mid_rst_err", 32'(err), 0);
      check("mid_rst_idata", idata, 0);
      tick();
      busy = 1'b0;
      reset = 1'b0;
      tick();
      check("post_rst_done", 32'(done), 0);
      check("post_rst_xfull", 32'(x_full), 0);
      check("post_rst_idata", idata, 0);
      core_rd("post_rst_wih", 3'd0, 17'h65, 20'h12345);
      rd_addr = 17'hBF;
      #1;
      check("post_rst_out", 32'(rd_data), 20'h00ABC);
      for (int i = 0; i < 16; i++) push(32'h100 + 32'(i));
      check("full_flag", 32'(x_full), 1);
      check("full_noerr", 32'(err), 0);
      push(32'h1FF);
      check("overflow_err", 32'(err), 1);
      check("overflow_full", 32'(x_full), 1);
      check("full_head", idata, 32'h100);
      x_push = 1'b1; x_data = 32'h200; i_en = 1'b1;
      tick();
      x_push = 1'b0; i_en = 1'b0;
      check("pushpop_full", 32'(x_full), 1);
      check("pushpop_head", idata, 32'h101);
      for (int i = 0; i < 15; i++) begin
         i_en = 1'b1;
         tick();
         i_en = 1'b0;
         check($sformatf("drain%0d", i), idata, i < 14 ? 32'h102 + 32'(i) : 32'h200);
         check($sformatf("drain_full%0d", i), 32'(x_full), 0);
      end
      i_en = 1'b1;
      tick();
      i_en = 1'b0;
      check("drained_empty", idata, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/rnn_mem_host.md
# rnn_mem_host

Memory-and-input responder for the RNN core: answers its `mce`/`msel`/`maddr` memory port (weights, biases, config, hidden-state output) and its `i_en`/`idata` input stream, and drives `ready` to launch a run. Sits between the RNN core and the host/testbench side, which preloads banks, queues input vectors, starts runs and reads back results. All core-side timing matches what the core samples: combinational read data and a show-ahead input word.

## Interface

Parameters:
- `T_MAX`, 16: timesteps of output storage (output bank = `T_MAX`×64 words).
- `XQ_DEPTH`, 16: input-vector FIFO depth (power of two).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `busy` in 1: core busy.
- `ready` out 1: run request to core.
- `i_en` in 1: core pops one input word.
- `idata` out 32: FIFO head (show-ahead), one bit per input element.
- `mce` in 1: memory access enable.
- `msel` in 3: bank select.
- `maddr` in 17: word address.
- `mdata_w` in 20: write data (bank 101 only).
- `mdata_r` out 20: read data.
- `ld_en` in 1: host load strobe.
- `ld_sel` in 3: host load bank (000–100).
- `ld_addr` in 17: host load address.
- `ld_data` in 20: host load data.
- `x_push` in 1: host pushes one input word.
- `x_data` in 32: pushed word.
- `x_full` out 1: FIFO full.
- `start` in 1: host run request pulse.
- `done` out 1: one-cycle run-complete pulse.
- `rd_addr` in 17: host output-bank read address `{t,h}`.
- `rd_data` out 20: output-bank word at `rd_addr`, combinational.
- `err` out 1: sticky protocol error.

## Operation

- Bank map, 20-bit signed words:
  - 000: W_ih, 2048 words at `{h[5:0], j[4:0]}`.
  - 001: b_ih, 64 words.
  - 010: W_hh, 4096 words at `{h[5:0], k[5:0]}`.
  - 011: b_hh, 64 words.
  - 100: config; word 0 = T, the run executes T+1 timesteps.
  - 101: output, 64 words per timestep at `{t[10:0], h[5:0]}`; valid only for t < `T_MAX`.
  - 110/111: unmapped.
- Core read: `mdata_r` = word(`msel`, `maddr`) when `mce`=1 and `msel`≠101, else 0.
  - Address out of bank range or unmapped bank → 0.
- Core write: at an edge with `mce`=1 and `msel`=101, store `mdata_w` at `maddr`.
  - t ≥ `T_MAX` → write dropped, `err` set.
  - Reads of bank 101 return 0.
- Host load: edge with `ld_en`=1, `busy`=0 and `ready`=0 writes `ld_data` to (`ld_sel`, `ld_addr`).
  - Ignored in any other case.
  - `ld_sel` ≥ 101 or address out of range → ignored.
- Input FIFO: `x_push` writes the tail when not full; `i_en` pops the head.
  - Push and pop in the same cycle → both occur, count unchanged.
  - Push while full → dropped, `err` set.
  - `i_en` while empty → no pop, `err` set, `idata` = 0.
- Run control, states IDLE → ARMED → RUN → IDLE:
  - IDLE: `start`=1 → ARMED.
  - ARMED: `ready`=1. `busy` sampled 1 → RUN, with `ready`=0 from the next cycle.
  - RUN: `busy` sampled 0 → IDLE and `done`=1 for one cycle.
  - `start` in ARMED or RUN → ignored.
- `err` clears only on reset.
- Memory arrays are not reset; contents persist across runs.

## Timing

- Reset values: `ready`=0, `done`=0, `err`=0, `x_full`=0, FIFO empty, `idata`=0, state IDLE.
- `mdata_r`, `idata` and `rd_data` are combinational outputs.
- `mdata_r`: core drives `msel`/`maddr` after edge N and samples `mdata_r` at edge N+1 (zero-wait read).
- `idata`: FIFO head is valid whenever the FIFO is non-empty. A pop at edge N exposes the next word after N. The core raising `i_en` after edge N samples the head at edge N+1, and that same edge performs the pop.
- `x_full` is registered, valid the cycle after the edge that fills the FIFO.
- Host-loaded and core-written words are readable from the cycle after the write edge.
- `ready` rises the cycle after the `start` edge and falls the cycle after `busy` is first sampled high.
- `done` is high the cycle after `busy` is first sampled 0 in RUN.
- Reset mid-run: state returns to IDLE, FIFO is flushed, memory is kept, and no `done` is issued.

## Test plan

- Reset mid-run: assert `reset` while `busy`=1 → `ready`=0, `done`=0, `err`=0, `idata`=0 immediately. After release, FIFO is empty and earlier loads are retained.
- Loads and reads: load W_ih[{3,5}]=0x12345 and b_hh[7]=0xFFFFE, then `start`. Core drives `msel`=000, `maddr`=0x65 → `mdata_r`=0x12345 in the same cycle. `msel`=011, `maddr`=7 → 0xFFFFE. `msel`=110 → 0.
- Input FIFO: push 0xA5A5A5A5 then 0x0F0F0F0F, then `i_en` for one cycle → core samples 0xA5A5A5A5 and `idata` then shows 0x0F0F0F0F. A further two pops → second pop sets `err`, `idata`=0.
- Handshake: `start` pulse → `ready`=1 next cycle. Hold `busy`=0 for 3 cycles → `ready` stays 1. Raise `busy` → `ready` drops next cycle. Drop `busy` after 10 cycles → `done` is a 1-cycle pulse. A `start` during RUN is ignored.
- Output writes: core writes 0x00ABC at `{t=2,h=63}` → `rd_addr`=0xBF returns 0x00ABC. A write at t=16 with `T_MAX`=16 → dropped, `err`=1.
- Full FIFO: push 17 words with `XQ_DEPTH`=16 → `x_full`=1, 17th dropped, `err`=1. Simultaneous push+pop while full → count stays 16, head advances.
